// File: rtl/rv_lsu_pkg.sv
// Shared LSU definitions: func3 width codes, FSM states, access decode helpers.
package rv_lsu_pkg;

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3D  = 3'b011;
  localparam logic [2:0] F3BU = 3'b100;
  localparam logic [2:0] F3HU = 3'b101;
  localparam logic [2:0] F3WU = 3'b110;

  localparam int unsigned LsuMaxWaitDefault = 255;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SzByte   = 2'd0,
    SzHalf   = 2'd1,
    SzWord   = 2'd2,
    SzDouble = 2'd3
  } lsu_size_e;

  typedef struct packed {
    lsu_size_e size;
    logic      uns;
  } lsu_access_t;

  // Unlisted codes fall back to the native word (W on RV32, D on RV64).
  function automatic lsu_access_t decode_f3(input logic [2:0] f3, input logic wide);
    lsu_access_t a;
    a.uns  = 1'b0;
    a.size = wide ? SzDouble : SzWord;
    case (f3)
      F3B:  a.size = SzByte;
      F3H:  a.size = SzHalf;
      F3W:  a.size = SzWord;
      F3D:  a.size = wide ? SzDouble : SzWord;
      F3BU: begin a.size = SzByte; a.uns = 1'b1; end
      F3HU: begin a.size = SzHalf; a.uns = 1'b1; end
      F3WU: if (wide) begin a.size = SzWord; a.uns = 1'b1; end
      default: ;
    endcase
    return a;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [2:0] a);
    logic m;
    case (size)
      SzByte:  m = 1'b0;
      SzHalf:  m = a[0];
      SzWord:  m = |a[1:0];
      default: m = |a;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane logic: store shift/strobes and load extract with sign/zero extension.
module rv_lsu_align
  import rv_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]                 size,
  input  logic                       uns,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [XLEN-1:0]            wd,
  input  logic [XLEN-1:0]            rdata,
  output logic [XLEN/8-1:0]          wstrb,
  output logic [XLEN-1:0]            wdata,
  output logic [XLEN-1:0]            rd
);
  localparam int unsigned NB = XLEN / 8;

  logic [NB-1:0]   mask;
  logic [XLEN-1:0] lane;
  logic            fill;
  int              nbits;

  always_comb begin
    mask  = '1;
    nbits = XLEN;
    case (lsu_size_e'(size))
      SzByte:  begin mask = NB'(1);  nbits = 8;  end
      SzHalf:  begin mask = NB'(3);  nbits = 16; end
      SzWord:  begin mask = NB'(15); nbits = 32; end
      default: ;
    endcase
    wstrb = mask << off;
    wdata = wd << {off, 3'b000};
    lane  = rdata >> {off, 3'b000};
    fill  = ~uns & lane[nbits-1];
    rd    = lane;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= nbits) rd[i] = fill;
    end
  end

endmodule

// File: rtl/rv_lsu.sv
// MEM-stage load/store unit on a req/gnt/rvalid bus; stalls the pipeline while an
// access is outstanding and aborts it after MAX_WAIT cycles in REQ/WAIT.
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = LsuMaxWaitDefault
) (
  input  logic              i_lsu_clk,
  input  logic              i_lsu_rstn,
  input  logic              i_lsu_valid,
  input  logic              i_lsu_we,
  input  logic [2:0]        i_lsu_bytectrl,
  input  logic [XLEN-1:0]   i_lsu_addr,
  input  logic [XLEN-1:0]   i_lsu_wd,
  output logic              o_lsu_stall,
  output logic [XLEN-1:0]   o_lsu_rd,
  output logic              o_lsu_rd_valid,
  output logic              o_lsu_misalign,
  output logic              o_lsu_timeout,
  output logic              o_lsu_bus_req,
  input  logic              i_lsu_bus_gnt,
  output logic [XLEN-1:0]   o_lsu_bus_addr,
  output logic              o_lsu_bus_we,
  output logic [XLEN/8-1:0] o_lsu_bus_wstrb,
  output logic [XLEN-1:0]   o_lsu_bus_wdata,
  input  logic              i_lsu_bus_rvalid,
  input  logic [XLEN-1:0]   i_lsu_bus_rdata
);
  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OffW = $clog2(NB);
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  lsu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  lsu_access_t     acc_in, acc_q, acc_sel;
  logic [OffW-1:0] off_q, off_sel;
  logic            aligned, accept, busy, complete, limit, timeout_hit, rd_valid;
  logic [XLEN-1:0] rd_q, al_rd, al_wdata, bus_addr_q, bus_wdata_q;
  logic [NB-1:0]   al_wstrb, bus_wstrb_q;
  logic            bus_we_q, load_ok_q, timeout_q;

  assign acc_in      = decode_f3(i_lsu_bytectrl, XLEN == 64);
  assign aligned     = ~is_misaligned(acc_in.size, i_lsu_addr[2:0]);
  assign accept      = i_lsu_valid & aligned & (state_q == StIdle);
  assign busy        = (state_q == StReq) | (state_q == StWait);
  assign complete    = ((state_q == StReq) & i_lsu_bus_gnt & bus_we_q) |
                       ((state_q == StWait) & i_lsu_bus_rvalid);
  assign limit       = (cnt_q + CntW'(1)) == CntW'(MAX_WAIT);
  assign timeout_hit = busy & limit & ~complete;
  assign cnt_d       = busy ? cnt_q + CntW'(1) : '0;

  // Store lanes come from the live request in IDLE; load extraction uses the captured access.
  assign acc_sel = (state_q == StIdle) ? acc_in : acc_q;
  assign off_sel = (state_q == StIdle) ? i_lsu_addr[OffW-1:0] : off_q;

  rv_lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .size  (acc_sel.size),
    .uns   (acc_sel.uns),
    .off   (off_sel),
    .wd    (i_lsu_wd),
    .rdata (i_lsu_bus_rdata),
    .wstrb (al_wstrb),
    .wdata (al_wdata),
    .rd    (al_rd)
  );

  always_ff @(posedge i_lsu_clk or negedge i_lsu_rstn) begin
    if (!i_lsu_rstn) state_q <= StIdle;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StReq;
      StReq: begin
        if (complete || limit)   state_d = StDone;
        else if (i_lsu_bus_gnt)  state_d = StWait;
      end
      StWait:  if (complete || limit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Stall is gated by reset so an abandoned access releases the pipeline at once.
  always_comb begin
    rd_valid       = (state_q == StDone) & load_ok_q;
    o_lsu_bus_req  = (state_q == StReq);
    o_lsu_stall    = i_lsu_rstn & i_lsu_valid & aligned & (state_q != StDone);
    o_lsu_misalign = i_lsu_rstn & i_lsu_valid & ~aligned & (state_q == StIdle);
    o_lsu_rd_valid = rd_valid;
    o_lsu_timeout  = (state_q == StDone) & timeout_q;
    o_lsu_rd       = rd_valid ? rd_q : '0;
  end

  always_ff @(posedge i_lsu_clk or negedge i_lsu_rstn) begin
    if (!i_lsu_rstn) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      off_q       <= '0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      rd_q        <= '0;
      load_ok_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        acc_q       <= acc_in;
        off_q       <= i_lsu_addr[OffW-1:0];
        bus_addr_q  <= i_lsu_addr & ~XLEN'(NB - 1);
        bus_we_q    <= i_lsu_we;
        bus_wstrb_q <= al_wstrb;
        bus_wdata_q <= al_wdata;
        load_ok_q   <= 1'b0;
        timeout_q   <= 1'b0;
      end
      if ((state_q == StWait) && i_lsu_bus_rvalid) begin
        rd_q      <= al_rd;
        load_ok_q <= 1'b1;
      end
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign o_lsu_bus_addr  = bus_addr_q;
  assign o_lsu_bus_we    = bus_we_q;
  assign o_lsu_bus_wstrb = bus_wstrb_q;
  assign o_lsu_bus_wdata = bus_wdata_q;

endmodule

// File: doc/rv_lsu.md
# rv_lsu

Parametrised load/store unit replacing the single-cycle data-memory path of the pipelined core's MEM stage. It drives a variable-latency data bus with a request/grant/response handshake, generates byte strobes and load sign/zero extension, flags misaligned accesses, and aborts stuck accesses on timeout. It asserts a stall to the hazard unit so the whole pipeline freezes while an access is outstanding.

## Interface
- XLEN, 32: data/address width; legal values are 32 and 64.
- MAX_WAIT, 255: cycles allowed in REQ+WAIT before an abort; legal range ≥ 1.
- i_lsu_clk  in  1  core clock.
- i_lsu_rstn  in  1  reset. One clock; reset is asynchronous and active-low.
- i_lsu_valid  in  1  a load or store is present in MEM.
- i_lsu_we  in  1  1 = store, 0 = load.
- i_lsu_bytectrl  in  3  func3: 000 B, 001 H, 010 W, 100 BU, 101 HU; when XLEN=64 also 011 D and 110 WU.
- i_lsu_addr  in  XLEN  byte address.
- i_lsu_wd  in  XLEN  store data, right-aligned.
- o_lsu_stall  out  1  freeze IF..MEM (to hazard unit).
- o_lsu_rd  out  XLEN  extended load data.
- o_lsu_rd_valid  out  1  one-cycle pulse; o_lsu_rd is valid.
- o_lsu_misalign  out  1  one-cycle pulse on a misaligned access.
- o_lsu_timeout  out  1  one-cycle pulse on an aborted access.
- o_lsu_bus_req  out  1  bus request.
- i_lsu_bus_gnt  in  1  request accepted.
- o_lsu_bus_addr  out  XLEN  address aligned to XLEN/8 bytes (low bits zero).
- o_lsu_bus_we  out  1  write.
- o_lsu_bus_wstrb  out  XLEN/8  byte-lane enables.
- o_lsu_bus_wdata  out  XLEN  store data shifted into its lanes.
- i_lsu_bus_rvalid  in  1  read response.
- i_lsu_bus_rdata  in  XLEN  read data, full bus word.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset enters IDLE, and the timeout counter clears to 0.
- IDLE with i_lsu_valid and an aligned access:
  - Register the bus address, we, strobes and shifted wdata.
  - Go to REQ.
- IDLE with i_lsu_valid and a misaligned access:
  - Misaligned means H/HU with addr[0]≠0, W/WU with addr[1:0]≠0, or D with addr[2:0]≠0.
  - Pulse o_lsu_misalign for that cycle. Issue no bus access and do not stall; o_lsu_rd = 0.
  - Stay in IDLE. The flag is raised once per instruction, because the pipeline advances.
- Unlisted func3 codes are treated as W (XLEN=32) or D (XLEN=64).
- REQ: assert o_lsu_bus_req. When i_lsu_bus_gnt is seen, a store goes to DONE and a load goes to WAIT.
- WAIT: on i_lsu_bus_rvalid, capture the lane-selected byte(s) from rdata, extend them per bytectrl, and go to DONE.
- Timeout: the counter increments every cycle spent in REQ or WAIT. When it reaches MAX_WAIT with no completion:
  - Drop req and go to DONE.
  - In DONE, o_lsu_timeout pulses and o_lsu_rd = 0.
- DONE:
  - o_lsu_stall = 0. The pipeline advances and the instruction leaves MEM.
  - o_lsu_rd_valid = 1 for loads that completed normally.
  - Clear the counter and go to IDLE.
  - i_lsu_valid in DONE never starts a new access.
- o_lsu_stall = i_lsu_valid & aligned & (state ≠ DONE). It is combinational.
- Strobes: the B/H/W/D mask is shifted left by addr[log2(XLEN/8)-1:0]. wdata is shifted left by 8× the same offset.
- i_lsu_bus_rvalid outside WAIT is ignored. This covers late responses after an abort.

## Timing
- Reset values: all outputs are 0 and the state is IDLE. Asserting rstn mid-access drops req immediately (asynchronous) and abandons the access.
- While req=1 and gnt=0, addr, we, wstrb and wdata stay stable.
- Minimum load: C0 IDLE (stall) → C1 REQ with gnt → C2 WAIT with rvalid → C3 DONE (rd_valid, no stall). This is 3 stall cycles.
- Minimum store: C0 IDLE → C1 REQ with gnt → C2 DONE. This is 2 stall cycles.
- Bus rule: rvalid comes no earlier than the cycle after gnt. rvalid in the same cycle as gnt is ignored.
- Timeout abort: DONE occurs exactly MAX_WAIT+1 cycles after the IDLE cycle that accepted the access.

## Structure
- Add to the shared rv_configs include:
  - the func3 width encodings (B/H/W/D/BU/HU/WU);
  - the LSU state encodings;
  - the default MAX_WAIT.
- One sub-module, rv_lsu_align, is combinational and contains:
  - store lane shift and strobe generation;
  - load lane extract and sign/zero extension.
- rv_lsu holds the FSM, the timeout counter and the registered bus outputs.

## Test plan
- LW, addr 0x104, XLEN=32, gnt in C1, rvalid in C2 with rdata 0xDEADBEEF → stall for C0–C2, rd_valid in C3, rd = 0xDEADBEEF, bus_addr = 0x104.
- LB at addr 0x103 with rdata 0x80123456 → rd = 0xFFFFFF80. LBU at the same address → rd = 0x00000080.
- SH at addr 0x102 with wd 0x0000ABCD, gnt held off 4 cycles → wstrb = 1100, wdata = 0xABCD0000, both held stable while waiting, DONE 1 cycle after gnt.
- LW at addr 0x101 → misalign pulses for 1 cycle, no req, stall = 0.
- MAX_WAIT=4, load granted but rvalid never comes → timeout pulses in the DONE cycle, rd = 0, no rd_valid. A later rvalid in IDLE is ignored.
- rstn asserted in WAIT → req = 0 and stall = 0 immediately; after release, the next LW completes normally. An XLEN=64 LD at 0x108 → wstrb all ones.
